// File: rtl/mul_div_unit_if.sv
// Request/response bundle between the execute-stage control unit and mul_div_unit.
// The control unit drives start/op/operands; the engine returns busy/done/result.
interface mul_div_unit_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [2:0]       op;
  logic [WIDTH-1:0] src_a;
  logic [WIDTH-1:0] src_b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;

  modport master (output start, op, src_a, src_b, input busy, done, result);
  modport slave  (input start, op, src_a, src_b, output busy, done, result);
endinterface

// File: rtl/mul_div_unit.sv
// Iterative RV32M multiply/divide: radix-2 shift-add multiplier and restoring divider on one datapath.
// Optional MULDIV_EARLY_OUT_EN: zero-operand multiply, divide-by-zero and signed overflow bypass the iterations.
module mul_div_unit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic          clk,
  input  logic          rst_n,
  mul_div_unit_if.slave bus
);
  typedef enum logic [1:0] {S_IDLE, S_PREP, S_RUN, S_FIN} state_t;

  state_t           r_state;
  logic [2:0]       r_op;
  logic [WIDTH-1:0] r_a, r_b, r_opnd, r_hi, r_lo, r_result;
  logic             r_neg_q, r_neg_r, r_dz, r_busy, r_done;
  logic [CNT_W-1:0] r_cnt;
`ifdef MULDIV_EARLY_OUT_EN
  logic             r_early;
  logic             w_early;
`endif

  logic               w_is_div, w_a_sgn, w_b_sgn, w_neg_a, w_neg_b, w_sub_ok;
  logic [WIDTH-1:0]   w_mag_a, w_mag_b, w_diff, w_run_hi, w_run_lo;
  logic [WIDTH:0]     w_mul_sum, w_rem_sh;
  logic [2*WIDTH-1:0] w_prod, w_prod_fix;
  logic [WIDTH-1:0]   w_quo, w_rem, w_sel;

  assign w_is_div = r_op[2];
  assign w_a_sgn  = (r_op == 3'b001) || (r_op == 3'b010) || (w_is_div && !r_op[0]);
  assign w_b_sgn  = (r_op == 3'b001) || (w_is_div && !r_op[0]);
  assign w_neg_a  = w_a_sgn & r_a[WIDTH-1];
  assign w_neg_b  = w_b_sgn & r_b[WIDTH-1];
  assign w_mag_a  = w_neg_a ? -r_a : r_a;
  assign w_mag_b  = w_neg_b ? -r_b : r_b;

  // r_opnd is the multiplicand for multiply and the divisor for divide; r_lo is the multiplier/quotient.
  assign w_mul_sum = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_opnd} : '0);
  assign w_rem_sh  = {r_hi, r_lo[WIDTH-1]};
  assign w_sub_ok  = (w_rem_sh >= {1'b0, r_opnd});
  assign w_diff    = w_rem_sh[WIDTH-1:0] - r_opnd;

  always_comb begin
    w_run_hi = w_mul_sum[WIDTH:1];
    w_run_lo = {w_mul_sum[0], r_lo[WIDTH-1:1]};
    if (w_is_div) begin
      w_run_hi = w_sub_ok ? w_diff : w_rem_sh[WIDTH-1:0];
      w_run_lo = {r_lo[WIDTH-2:0], w_sub_ok};
    end
  end

  // A zero divisor leaves an all-ones quotient and a remainder equal to the original dividend.
  assign w_prod     = {r_hi, r_lo};
  assign w_prod_fix = r_neg_q ? -w_prod : w_prod;
  assign w_quo      = r_dz ? '1  : (r_neg_q ? -r_lo : r_lo);
  assign w_rem      = r_dz ? r_a : (r_neg_r ? -r_hi : r_hi);

  always_comb begin
    case (r_op)
      3'b000:                 w_sel = w_prod_fix[WIDTH-1:0];
      3'b001, 3'b010, 3'b011: w_sel = w_prod_fix[2*WIDTH-1:WIDTH];
      3'b100, 3'b101:         w_sel = w_quo;
      default:                w_sel = w_rem;
    endcase
  end

`ifdef MULDIV_EARLY_OUT_EN
  assign w_early = (w_is_div && (r_b == '0))
                || (w_is_div && !r_op[0] && (r_a == {1'b1, {(WIDTH-1){1'b0}}}) && (r_b == '1))
                || (!w_is_div && ((r_a == '0) || (r_b == '0)));
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_op     <= '0;
      r_a      <= '0;
      r_b      <= '0;
      r_opnd   <= '0;
      r_hi     <= '0;
      r_lo     <= '0;
      r_result <= '0;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
      r_dz     <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_cnt    <= '0;
`ifdef MULDIV_EARLY_OUT_EN
      r_early  <= 1'b0;
`endif
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            r_op    <= bus.op;
            r_a     <= bus.src_a;
            r_b     <= bus.src_b;
            r_busy  <= 1'b1;
            r_state <= S_PREP;
          end
        end
        S_PREP: begin
          r_neg_q <= w_neg_a ^ w_neg_b;
          r_neg_r <= w_neg_a;
          r_dz    <= w_is_div && (r_b == '0);
          r_opnd  <= w_is_div ? w_mag_b : w_mag_a;
          r_lo    <= w_is_div ? w_mag_a : w_mag_b;
          r_hi    <= '0;
          r_cnt   <= '0;
`ifdef MULDIV_EARLY_OUT_EN
          // Early cases pass through RUN for a single held cycle so done lands three edges after accept.
          r_early <= w_early;
          if (w_early) begin
            r_cnt <= CNT_W'(WIDTH-1);
            if (!w_is_div) r_lo <= '0;
          end
`endif
          r_state <= S_RUN;
        end
        S_RUN: begin
`ifdef MULDIV_EARLY_OUT_EN
          if (!r_early) begin
            r_hi <= w_run_hi;
            r_lo <= w_run_lo;
          end
`else
          r_hi <= w_run_hi;
          r_lo <= w_run_lo;
`endif
          r_cnt <= r_cnt + CNT_W'(1);
          if (r_cnt == CNT_W'(WIDTH-1)) r_state <= S_FIN;
        end
        S_FIN: begin
          r_result <= w_sel;
          r_done   <= 1'b1;
          r_busy   <= 1'b0;
          r_state  <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.busy   = r_busy;
  assign bus.done   = r_done;
  assign bus.result = r_result;
endmodule

// File: tb/tb_mul_div_unit.sv
// Self-checking bench for mul_div_unit: vector table with a result scoreboard, plus
// hand-written sequences for start-while-busy and asynchronous reset mid-operation.
module tb_mul_div_unit;
  localparam int WIDTH = 32;
  localparam logic [2:0] OP_MUL = 3'b000, OP_MULH = 3'b001, OP_MULHSU = 3'b010, OP_MULHU = 3'b011;
  localparam logic [2:0] OP_DIV = 3'b100, OP_DIVU = 3'b101, OP_REM = 3'b110, OP_REMU = 3'b111;
`ifdef MULDIV_EARLY_OUT_EN
  localparam bit EO = 1'b1;
`else
  localparam bit EO = 1'b0;
`endif

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    string       name;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mul_div_unit_if #(.WIDTH(WIDTH)) bus();
  mul_div_unit #(.WIDTH(WIDTH), .CNT_W(6)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  int          pass_cnt = 0;
  int          chk_cnt  = 0;
  logic [31:0] sb_q[$];
  vec_t        vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  function automatic vec_t mk(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                              input logic [31:0] exp, input string name);
    vec_t v;
    v.op = op; v.a = a; v.b = b; v.exp = exp; v.name = name;
    return v;
  endfunction

  function automatic int exp_lat(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    bit early;
    early = (op[2] && b == 32'h0)
         || ((op == OP_DIV || op == OP_REM) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
         || (!op[2] && (a == 32'h0 || b == 32'h0));
    return (EO && early) ? 3 : 34;
  endfunction

  // Issue one op, push its expectation, then scramble the inputs; poke_cyc >= 0 re-pulses start mid-run.
  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp, input string name, input int poke_cyc);
    int cyc;
    bit busy_ok;
    logic [31:0] want;
    @(negedge clk);
    bus.start = 1'b1; bus.op = op; bus.src_a = a; bus.src_b = b;
    sb_q.push_back(exp);
    @(posedge clk); #1;
    chk({name, " busy"}, 32'(bus.busy), 32'd1);
    @(negedge clk);
    bus.start = 1'b0; bus.op = 3'($urandom); bus.src_a = $urandom; bus.src_b = $urandom;
    cyc = 0;
    busy_ok = 1'b1;
    while (!bus.done && cyc < 200) begin
      @(posedge clk); #1;
      cyc++;
      if (cyc == poke_cyc) begin
        bus.start = 1'b1; bus.op = OP_MUL; bus.src_a = 32'd5; bus.src_b = 32'd6;
      end else begin
        bus.start = 1'b0;
      end
      if (!bus.done && !bus.busy) busy_ok = 1'b0;
    end
    bus.start = 1'b0;
    if (!bus.done) begin
      chk({name, " done timeout"}, 32'(cyc), 32'(exp_lat(op, a, b)));
      sb_q.delete();
    end else begin
      want = sb_q.pop_front();
      chk({name, " result"}, bus.result, want);
      chk({name, " latency"}, 32'(cyc), 32'(exp_lat(op, a, b)));
      if (poke_cyc >= 0) chk({name, " busy held"}, 32'(busy_ok), 32'd1);
      @(posedge clk); #1;
      chk({name, " done pulse"}, 32'(bus.done), 32'd0);
      chk({name, " result hold"}, bus.result, want);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int done_seen;
    bus.start = 1'b0; bus.op = 3'b000; bus.src_a = '0; bus.src_b = '0;

    vecs.push_back(mk(OP_MUL,    32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB, "mul 7x-3"));
    vecs.push_back(mk(OP_MULHU,  32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE, "mulhu ffff"));
    vecs.push_back(mk(OP_MULH,   32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'h0000_0000, "mulh -1x-1"));
    vecs.push_back(mk(OP_MULHSU, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFF, "mulhsu ffff"));
    vecs.push_back(mk(OP_DIV,    32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD, "div -7/2"));
    vecs.push_back(mk(OP_REM,    32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF, "rem -7/2"));
    vecs.push_back(mk(OP_DIVU,   32'd100,        32'd7,         32'd14,        "divu 100/7"));
    vecs.push_back(mk(OP_REMU,   32'd100,        32'd7,         32'd2,         "remu 100/7"));
    vecs.push_back(mk(OP_DIVU,   32'h1234,       32'd0,         32'hFFFF_FFFF, "divu by 0"));
    vecs.push_back(mk(OP_REM,    32'h1234,       32'd0,         32'h1234,      "rem by 0"));
    vecs.push_back(mk(OP_DIV,    32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, "div ovf"));
    vecs.push_back(mk(OP_REM,    32'h8000_0000,  32'hFFFF_FFFF, 32'h0000_0000, "rem ovf"));
    vecs.push_back(mk(OP_DIV,    32'hFFFF_FFFF,  32'd0,         32'hFFFF_FFFF, "div -1/0"));
    vecs.push_back(mk(OP_REM,    32'hFFFF_FFF9,  32'd0,         32'hFFFF_FFF9, "rem -7/0"));
    vecs.push_back(mk(OP_MUL,    32'd0,          32'h0001_2345, 32'h0000_0000, "mul 0xb"));
    vecs.push_back(mk(OP_MULHU,  32'h8000_0000,  32'h8000_0000, 32'h4000_0000, "mulhu 2^31sq"));
    vecs.push_back(mk(OP_MULH,   32'h8000_0000,  32'h8000_0000, 32'h4000_0000, "mulh min sq"));
    vecs.push_back(mk(OP_MULH,   32'h8000_0000,  32'd1,         32'hFFFF_FFFF, "mulh min x1"));
    vecs.push_back(mk(OP_DIV,    32'd20,         32'hFFFF_FFFA, 32'hFFFF_FFFD, "div 20/-6"));
    vecs.push_back(mk(OP_REM,    32'd20,         32'hFFFF_FFFA, 32'd2,         "rem 20/-6"));
    vecs.push_back(mk(OP_REMU,   32'hFFFF_FFFF,  32'h10,        32'hF,         "remu ffff/16"));
    vecs.push_back(mk(OP_DIVU,   32'hFFFF_FFFF,  32'd1,         32'hFFFF_FFFF, "divu ffff/1"));

    #1;
    chk("reset busy",   32'(bus.busy), 32'd0);
    chk("reset done",   32'(bus.done), 32'd0);
    chk("reset result", bus.result,    32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    foreach (vecs[i]) run_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp, vecs[i].name, -1);

    run_op(OP_DIVU, 32'd100, 32'd7, 32'd14, "divu start-while-busy", 10);

    @(negedge clk);
    bus.start = 1'b1; bus.op = OP_MUL; bus.src_a = 32'd3; bus.src_b = 32'd5;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (14) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midop reset busy",   32'(bus.busy), 32'd0);
    chk("midop reset done",   32'(bus.done), 32'd0);
    chk("midop reset result", bus.result,    32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    done_seen = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (bus.done) done_seen++;
    end
    chk("no done after reset", 32'(done_seen), 32'd0);
    run_op(OP_MUL, 32'd3, 32'd5, 32'd15, "mul after reset", -1);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end
endmodule
